// File: rtl/sumador_pkg.sv
// Shared types and default geometry for the multi-cycle wide adder/subtractor.
package sumador_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;

  localparam int CHUNK_W_DEF    = 4;
  localparam int NUM_CHUNKS_DEF = 8;

  // Slice counter never narrower than one bit, even for a single-slice build.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/Sumador_Completo.sv
// Purpose: N-bit ripple full adder, S = A + B + Cin with carry out.
// Latency: combinational.
// Backpressure: none.
module Sumador_Completo #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};

endmodule

// File: rtl/sumador_multiciclo.sv
// Purpose: W-bit add/sub built from one CHUNK_W-bit adder, one slice per clock, LSB first.
// Latency: done_o NUM_CHUNKS cycles after the accepting edge; one op per NUM_CHUNKS+1 cycles.
// Backpressure: start_i is only accepted in IDLE or DONE; it is ignored while busy_o is high.
module sumador_multiciclo
  import sumador_pkg::*;
#(
  parameter  int CHUNK_W    = CHUNK_W_DEF,
  parameter  int NUM_CHUNKS = NUM_CHUNKS_DEF,
  localparam int W          = CHUNK_W * NUM_CHUNKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_o,
  output logic         cout_o,
  output logic         ovf_o
);

  localparam int CNT_W = cnt_width(NUM_CHUNKS);

  estado_t             state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [W-1:0]        a_sh_q, a_sh_d;
  logic [W-1:0]        b_sh_q, b_sh_d;
  logic [W-1:0]        res_sh_q, res_sh_d;
  logic [W-1:0]        result_q, result_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CHUNK_W-1:0]  s_slice;
  logic                s_cout;
  logic [W-1:0]        res_next;

  Sumador_Completo #(CHUNK_W) u_adder (
    .A    (a_sh_q[CHUNK_W-1:0]),
    .B    (b_sh_q[CHUNK_W-1:0]),
    .Cin  (carry_q),
    .S    (s_slice),
    .Cout (s_cout)
  );

  // New slice enters at the top; after NUM_CHUNKS shifts slice 0 sits at the LSB.
  assign res_next = (res_sh_q >> CHUNK_W) | (W'(s_slice) << (W - CHUNK_W));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          a_sh_d  = op_a;
          b_sh_d  = sub_i ? ~op_b : op_b;
          carry_d = sub_i;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> CHUNK_W;
        b_sh_d   = b_sh_q >> CHUNK_W;
        res_sh_d = res_next;
        carry_d  = s_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
          state_d  = DONE;
          result_d = res_next;
          cout_d   = s_cout;
          // Carry into the MSB is recovered from the sum bit of the last slice.
          ovf_d    = a_sh_q[CHUNK_W-1] ^ b_sh_q[CHUNK_W-1] ^ s_slice[CHUNK_W-1] ^ s_cout;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

endmodule

// File: doc/sumador_multiciclo.md
Name: sumador_multiciclo

Overview:
- Multi-cycle wide adder/subtractor for the SIMD datapath.
- Computes a W-bit sum or difference by feeding CHUNK_W-bit slices, LSB first, through one instance of the team's CHUNK_W-bit full adder, one slice per clock.
- The inter-slice carry is registered between cycles.
- Sits directly upstream of the adder: it sequences its operands and carry-in, and consumes its S/Cout.

Parameters:
- CHUNK_W, 4, width of the adder instance (bits per slice)
- NUM_CHUNKS, 8, number of slices; W = CHUNK_W*NUM_CHUNKS (localparam, default 32)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- start_i  input  1  request; operands sampled on the edge that accepts it
- sub_i  input  1  0 = A+B, 1 = A-B
- op_a  input  W  operand A
- op_b  input  W  operand B
- busy_o  output  1  high while slices are being processed
- done_o  output  1  one-cycle pulse: result_o, cout_o and ovf_o are valid
- result_o  output  W  sum/difference
- cout_o  output  1  carry out of bit W-1 (for sub: 1 = no borrow)
- ovf_o  output  1  signed two's-complement overflow

Behaviour:
- Reset: all outputs 0, FSM = IDLE, slice counter 0, carry register 0. Reset mid-operation aborts it, and no done_o is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy_o=0. On start_i=1:
  - latch A and B' (B' = sub_i ? ~op_b : op_b);
  - carry register <= sub_i;
  - counter <= 0;
  - go to RUN.
- RUN: busy_o=1.
  - Adder inputs: A slice[cnt], B' slice[cnt], carry register. Slice k = bits [k*CHUNK_W +: CHUNK_W].
  - Each edge: capture S into the internal result slice cnt, carry register <= Cout, cnt <= cnt+1.
  - When cnt = NUM_CHUNKS-1: capture the final slice and go to DONE.
  - start_i is ignored in RUN.
- DONE entry edge:
  - result_o <= the full assembled result;
  - cout_o <= final Cout;
  - ovf_o <= carry into bit W-1 XOR final Cout. Carry into bit W-1 = A[W-1]^B'[W-1]^S[W-1].
- DONE: done_o=1 and busy_o=0 for exactly one cycle.
  - Next state: RUN if start_i=1 (operands latched, back-to-back operation); otherwise IDLE.
- Latency: start accepted at edge E0. done_o is high in the cycle between edges E0+NUM_CHUNKS and E0+NUM_CHUNKS+1. Throughput: one operation per NUM_CHUNKS+1 cycles.
- result_o, cout_o and ovf_o change only at DONE entry or on reset, and hold between operations.
- Operand inputs may change freely after the accepting edge.
- Counter width: $clog2(NUM_CHUNKS), minimum 1 bit. Arithmetic is modulo 2^W.
- NUM_CHUNKS=1 is legal: RUN lasts one cycle.

Decomposition:
- Package sumador_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;
  - default CHUNK_W/NUM_CHUNKS localparams.
- Sub-module: one instance of the existing parameterized full adder, Sumador_Completo #(CHUNK_W), ports (A,B,Cin,S,Cout). No other sub-modules.
- Operand and result slices are handled with shift registers (shift right by CHUNK_W per RUN edge), not wide muxes.

Test Plan (CHUNK_W=4, NUM_CHUNKS=8):
- Reset: hold rst 2 cycles, then release.
  - All outputs 0, busy_o=0.
  - start_i pulsed with rst=1: no busy, no done.
- Add 0x00000001 + 0xFFFFFFFE, sub=0.
  - busy_o high for 8 cycles, done_o at E0+8.
  - result_o=0xFFFFFFFF, cout_o=0, ovf_o=0.
- Add 0xFFFFFFFF + 0x00000001: carry ripples through all 8 slices.
  - result_o=0x00000000, cout_o=1, ovf_o=0.
  - Then 0x7FFFFFFF + 0x00000001: result_o=0x80000000, cout_o=0, ovf_o=1.
- Subtract, sub=1:
  - 0x00000005 - 0x00000007: result_o=0xFFFFFFFE, cout_o=0, ovf_o=0.
  - 0x80000000 - 0x00000001: result_o=0x7FFFFFFF, cout_o=1, ovf_o=1.
- Handshake: start_i held high with new operands during RUN.
  - Ignored: result equals the first operation.
  - start_i=1 in DONE with 0x10+0x20: no IDLE cycle; second done_o exactly 9 cycles after the first; result_o=0x00000030.
- Reset mid-RUN: rst asserted at 3rd RUN cycle.
  - Next cycle: busy_o=0, result_o=0, done_o never pulses.
  - A new start afterwards completes correctly: 0x12345678+0x11111111 -> 0x23456789.
